// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a registered result and valid/ready handshake
// on both sides. Single-cycle ops complete on the accept edge; MUL (shift-add)
// and DIV (restoring) iterate one bit per cycle.
// Optional macro SEQ_ALU_FLAGS_EN adds registered carry/overflow/negative.
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dst,
  output logic [WIDTH-1:0] dst2,
  output logic             zero,
  output logic             div_zero
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam logic [5:0] OP_ADD  = 6'b000100;
  localparam logic [5:0] OP_SUB  = 6'b000101;
  localparam logic [5:0] OP_MUL  = 6'b000110;
  localparam logic [5:0] OP_DIV  = 6'b000111;
  localparam logic [5:0] OP_OR   = 6'b001000;
  localparam logic [5:0] OP_XOR  = 6'b001001;
  localparam logic [5:0] OP_NAND = 6'b001010;
  localparam logic [5:0] OP_NOR  = 6'b001011;
  localparam logic [5:0] OP_XNOR = 6'b001100;
  localparam logic [5:0] OP_NOT  = 6'b001101;
  localparam logic [5:0] OP_SHL  = 6'b001110;
  localparam logic [5:0] OP_SHR  = 6'b001111;

  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;     // MUL partial product high / DIV remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // MUL multiplier / DIV dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d; // MUL multiplicand / DIV divisor
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] dst2_q, dst2_d;
  logic             zero_q, zero_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sub_r, shl_r, shr_r;
  logic             sh_big;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic             div_ge;
  logic             accept;

`ifdef SEQ_ALU_FLAGS_EN
  logic             cy_q, cy_d, vf_q, vf_d, neg_q, neg_d;
  logic             res_c, res_v;
  logic [WIDTH:0]   add_full;
`endif

  assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = ov_q;
  assign dst       = dst_q;
  assign dst2      = dst2_q;
  assign zero      = zero_q;
  assign div_zero  = divz_q;
`ifdef SEQ_ALU_FLAGS_EN
  assign carry     = cy_q;
  assign overflow  = vf_q;
  assign negative  = neg_q;
`endif

  // Single-cycle result: logic/arith ops plus a log-stage barrel shifter.
  always_comb begin
    sub_r  = b - a;
    shl_r  = a;
    shr_r  = a;
    for (int unsigned i = 0; i < SHW; i++) begin
      if (b[i]) begin
        shl_r = shl_r << (1 << i);
        shr_r = shr_r >> (1 << i);
      end
    end
    sh_big = |b[WIDTH-1:SHW];
    case (alu_control)
      6'b000000, 6'b000001, 6'b000010, 6'b000011: res = a;
      OP_SUB:  res = (b != '0) ? sub_r : ~a;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_SHL:  res = sh_big ? '0 : shl_r;
      OP_SHR:  res = sh_big ? '0 : shr_r;
      default: res = a + b;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  // Carry/overflow for single-cycle ops; every a+b opcode reports ADD flags.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (alu_control)
      6'b000000, 6'b000001, 6'b000010, 6'b000011,
      OP_MUL, OP_DIV, OP_OR, OP_XOR, OP_NAND, OP_NOR,
      OP_XNOR, OP_NOT, OP_SHL, OP_SHR: begin
        res_c = 1'b0;
        res_v = 1'b0;
      end
      OP_SUB: begin
        res_c = (b < a);
        res_v = (b[WIDTH-1] ^ a[WIDTH-1]) & (sub_r[WIDTH-1] ^ b[WIDTH-1]);
      end
      default: begin
        res_c = add_full[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end
`endif

  // Next-state: accept, iterate MUL/DIV, write result, handshake bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    ov_d    = ov_q && !out_ready;
    dst_d   = dst_q;
    dst2_d  = dst2_q;
    zero_d  = zero_q;
    divz_d  = divz_q;
`ifdef SEQ_ALU_FLAGS_EN
    cy_d    = cy_q;
    vf_d    = vf_q;
    neg_d   = neg_q;
`endif
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rs  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_rs >= {1'b0, opnd_q});

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_control == OP_MUL) begin
            state_d = MUL;
            cnt_d   = CNT_INIT;
            hi_d    = '0;
            lo_d    = b;
            opnd_d  = a;
          end else if (alu_control == OP_DIV) begin
            state_d = DIV;
            cnt_d   = CNT_INIT;
            hi_d    = '0;
            lo_d    = a;
            opnd_d  = b;
          end else begin
            ov_d   = 1'b1;
            dst_d  = '0;
            dst2_d = res;
            zero_d = (res == '0);
            divz_d = 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            cy_d   = res_c;
            vf_d   = res_v;
            neg_d  = res[WIDTH-1];
`endif
          end
        end
      end
      MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          ov_d    = 1'b1;
          dst_d   = hi_d;
          dst2_d  = lo_d;
          zero_d  = (lo_d == '0);
          divz_d  = 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
          cy_d    = (hi_d != '0);
          vf_d    = (hi_d != '0);
          neg_d   = lo_d[WIDTH-1];
`endif
        end
      end
      DIV: begin
        // Remainder always stays below the divisor, so a WIDTH-bit subtract suffices.
        hi_d  = div_ge ? (div_rs[WIDTH-1:0] - opnd_q) : div_rs[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          ov_d    = 1'b1;
          dst_d   = hi_d;
          dst2_d  = lo_d;
          zero_d  = (lo_d == '0);
          divz_d  = (opnd_q == '0);
`ifdef SEQ_ALU_FLAGS_EN
          cy_d    = 1'b0;
          vf_d    = 1'b0;
          neg_d   = lo_d[WIDTH-1];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; async reset abandons any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      ov_q    <= 1'b0;
      dst_q   <= '0;
      dst2_q  <= '0;
      zero_q  <= 1'b0;
      divz_q  <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      cy_q    <= 1'b0;
      vf_q    <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      ov_q    <= ov_d;
      dst_q   <= dst_d;
      dst2_q  <= dst2_d;
      zero_q  <= zero_d;
      divz_q  <= divz_d;
`ifdef SEQ_ALU_FLAGS_EN
      cy_q    <= cy_d;
      vf_q    <= vf_d;
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=16, default build).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, div_zero;
  logic [15:0] a, b, dst, dst2;
  logic [5:0]  alu_control;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .dst(dst), .dst2(dst2), .zero(zero),
    .div_zero(div_zero)
  );

  typedef struct {
    logic [15:0] d;
    logic [15:0] d2;
    logic        z;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    logic [31:0] p;
    e.d  = 16'h0000;
    e.dz = 1'b0;
    case (op)
      6'd0, 6'd1, 6'd2, 6'd3: e.d2 = x;
      6'd5:  e.d2 = (y != 0) ? 16'(y - x) : ~x;
      6'd6: begin
        p    = {16'h0, x} * {16'h0, y};
        e.d  = p[31:16];
        e.d2 = p[15:0];
      end
      6'd7: begin
        if (y == 0) begin
          e.d2 = 16'hFFFF;
          e.d  = x;
          e.dz = 1'b1;
        end else begin
          e.d2 = x / y;
          e.d  = x % y;
        end
      end
      6'd8:  e.d2 = x | y;
      6'd9:  e.d2 = x ^ y;
      6'd10: e.d2 = ~(x & y);
      6'd11: e.d2 = ~(x | y);
      6'd12: e.d2 = ~(x ^ y);
      6'd13: e.d2 = ~x;
      6'd14: e.d2 = (y >= 16) ? 16'h0 : 16'(x << y);
      6'd15: e.d2 = (y >= 16) ? 16'h0 : 16'(x >> y);
      default: e.d2 = 16'(x + y);
    endcase
    e.z = (e.d2 == 16'h0);
    return e;
  endfunction

  // Present one op from a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [15:0] x, input logic [15:0] y,
                       input bit push);
    int n;
    alu_control = op;
    a           = x;
    b           = y;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    if (push) sb.push_back(model(op, x, y));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycles from accept to out_valid, counting the accept edge as 1.
  task automatic expect_latency(input string tag, input int lat);
    int n;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, lat);
  endtask

  // Scoreboard: compare on every consumed result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("dst", dst, e.d);
          check("dst2", dst2, e.d2);
          check("zero", zero, e.z);
          check("div_zero", div_zero, e.dz);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   c0;
    bit   seen;
    logic [5:0]  rop;
    logic [15:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_control = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_dst", dst, 0);
    check("rst_dst2", dst2, 0);
    check("rst_zero", zero, 0);
    check("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Reset mid-MUL: nothing may come out.
    issue(6'd6, 16'd3, 16'd5, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dst", dst, 0);
    check("midrst_dst2", dst2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale", seen, 0);

    // ADD with backpressure.
    out_ready = 1'b0;
    issue(6'd4, 16'hFFFF, 16'h0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_dst2_hold", dst2, 16'h0000);
      check("bp_zero_hold", zero, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(negedge clk);

    // Latencies.
    issue(6'd6, 16'h1234, 16'h0100, 1'b1);
    expect_latency("lat_mul", 17);
    issue(6'd7, 16'd100, 16'd7, 1'b1);
    expect_latency("lat_div", 17);
    issue(6'd7, 16'd9, 16'd0, 1'b1);
    expect_latency("lat_div0", 17);
    issue(6'd5, 16'd3, 16'd10, 1'b1);
    expect_latency("lat_sub", 1);

    // SUB/negate and shift boundaries.
    issue(6'd5, 16'h00F0, 16'h0000, 1'b1);
    issue(6'd14, 16'h0001, 16'd15, 1'b1);
    issue(6'd14, 16'h0001, 16'd16, 1'b1);
    issue(6'd15, 16'h8000, 16'd3, 1'b1);
    issue(6'd15, 16'h8000, 16'd200, 1'b1);

    // Back-to-back streaming: one result per cycle.
    c0 = cyc;
    issue(6'd9,  16'hF0F0, 16'hFF00, 1'b1);
    issue(6'd10, 16'hF0F0, 16'hFF00, 1'b1);
    issue(6'd11, 16'hF0F0, 16'hFF00, 1'b1);
    issue(6'd12, 16'hF0F0, 16'hFF00, 1'b1);
    check("stream_cycles", cyc - c0, 4);

    // Random mix, including pass-through, default and multi-cycle opcodes.
    for (int i = 0; i < 12; i++) begin
      rop = 6'($urandom_range(0, 63));
      ra  = 16'($urandom);
      rb  = (i % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      issue(rop, ra, rb, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU, with a registered result and a valid/ready handshake on both sides.
- Keeps the existing 6-bit function-select encoding and per-opcode semantics.
- Multiply and divide are iterative (one bit per cycle), which removes the wide combinational multiplier/divider from the critical path.
- Sits between register-file read and writeback; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), derived width of the shift amount; not to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode presented
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_control  input  6  function select
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- dst  output  WIDTH  secondary result: MUL high half, DIV remainder, 0 otherwise
- dst2  output  WIDTH  primary result
- zero  output  1  (dst2 == 0), registered with the result
- div_zero  output  1  last DIV had b == 0

Behaviour:
- Reset (async, rst_n low):
  - FSM enters IDLE.
  - out_valid, dst, dst2, zero and div_zero all clear to 0.
  - Any in-flight MUL/DIV is abandoned; no result is produced.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - Accept and result consumption may happen in the same cycle.
  - A result holds stable until out_ready is high while out_valid is high.
- FSM states: IDLE, MUL, DIV.
  - IDLE + accept of a single-cycle op: the result is written and out_valid is set on the next edge (latency 1).
  - IDLE + accept of MUL (000110) or DIV (000111): operands are latched, a counter is loaded with WIDTH-1, and the FSM goes to MUL or DIV.
  - MUL: one shift-add step per cycle.
  - DIV: one restoring step per cycle.
  - When the counter reaches 0, the result is written, out_valid is set, and the FSM returns to IDLE.
  - MUL/DIV latency is WIDTH+1 cycles from the accept edge to out_valid.
- Opcodes (all arithmetic modulo 2^WIDTH, unsigned):
  - 000000–000011: dst2 = a.
  - 000100: a+b.
  - 000101: b−a if b != 0, otherwise ~a.
  - 000110: {dst, dst2} = a*b (full 2·WIDTH product).
  - 000111: dst2 = a/b, dst = a%b.
  - 001000: or.
  - 001001: xor.
  - 001010: nand.
  - 001011: nor.
  - 001100: xnor.
  - 001101: ~a.
  - 001110: a<<b.
  - 001111: a>>b (logical).
  - All other opcodes: a+b.
- Shifts: if b >= WIDTH, the result is 0. Otherwise the shift is done by a log-stage barrel shifter using b[SHW-1:0].
- DIV with b == 0: dst2 is all ones, dst = a, div_zero = 1. Still takes the full WIDTH+1 cycles.
- div_zero is updated on every result; it is 0 for non-DIV results.
- dst is 0 for every op except MUL and DIV.
- Ops accepted back-to-back are completed strictly in order; there is no overlap.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- Defined:
  - Adds outputs carry (1), overflow (1) and negative (1), registered with the result.
  - ADD: carry = bit WIDTH of a+b; overflow = signed overflow.
  - SUB: carry = borrow (b < a); overflow = signed overflow of b−a.
  - MUL: carry = overflow = (dst != 0).
  - negative = dst2[WIDTH-1] for all ops.
  - All other ops drive carry and overflow to 0.
  - All three flags reset to 0.
- Undefined: these ports and their logic do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset mid-MUL:
  - Stimulus: accept MUL a=3, b=5; assert rst_n low at cycle 4.
  - Response: out_valid=0, dst=dst2=0; in_ready=1 after release; no stale result appears.
- ADD with backpressure:
  - Stimulus: ADD a=16'hFFFF, b=16'h0001 with out_ready=0 for 3 cycles.
  - Response: dst2=0, zero=1, out_valid held for 3 cycles, in_ready=0; after out_ready=1, in_ready=1.
  - With SEQ_ALU_FLAGS_EN: carry=1.
- MUL latency:
  - Stimulus: MUL a=16'h1234, b=16'h0100.
  - Response: out_valid exactly 17 cycles after accept; dst=16'h0012, dst2=16'h3400.
- DIV by zero and normal DIV:
  - Stimulus: DIV a=100, b=7.
  - Response: dst2=14, dst=2, div_zero=0.
  - Stimulus: DIV a=9, b=0.
  - Response: dst2=16'hFFFF, dst=9, div_zero=1.
- SUB/negate and shifts:
  - SUB a=3, b=10 → 7.
  - SUB a=16'h00F0, b=0 → 16'hFF0F.
  - SHL a=1, b=15 → 16'h8000.
  - SHL a=1, b=16 → 0, zero=1.
  - SHR a=16'h8000, b=3 → 16'h1000.
- Back-to-back throughput:
  - Stimulus: in_valid held high with out_ready=1, streaming XOR, NAND, NOR, XNOR.
  - Response: one result per cycle in order.
  - For a=16'hF0F0, b=16'hFF00: XOR=16'h0FF0, NAND=16'h0FFF, NOR=16'h000F, XNOR=16'hF00F.
